wide_add_seq: RTL and testbench



---
 rtl/wide_add_seq.sv | 130 +++++++++++++
 tb/tb_wide_add_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WIDTH-bit adder/subtractor built from one external SLICE-bit
// carry-lookahead slice. It uses the slice once per beat for WIDTH/SLICE beats. The carry
// from each beat is held in a register and fed into the next beat.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake; req_ready_o is high only in idle
//   req_a_i, req_b_i, req_sub_i     operands and op select (1 = a - b); sampled at accept only
//   abort_i                         cancels an operation that is running (ignored otherwise)
//   resp_valid_o / resp_ready_i     response handshake; outputs stay stable until taken
//   resp_sum_o, resp_cout_o         result and carry out of the MSB (sub: 1 = no borrow)
//   resp_ovf_o                      two's-complement signed overflow
//   add_a_o, add_b_o, add_cin_o     drive the external slice (zero outside RUN)
//   add_sum_i, add_cout_i           combinational result from the external slice
module wide_add_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             req_sub_i,
    input  logic             abort_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_sum_o,
    output logic             resp_cout_o,
    output logic             resp_ovf_o,
    output logic [SLICE-1:0] add_a_o,
    output logic [SLICE-1:0] add_b_o,
    output logic             add_cin_o,
    input  logic [SLICE-1:0] add_sum_i,
    input  logic             add_cout_i
);

    localparam int unsigned NBEATS = WIDTH / SLICE;
    localparam int unsigned BeatW  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NBEATS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;        // B already inverted for subtract
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    int unsigned        off;

    assign off = 32'(beat_q) * SLICE;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        beat_d    = beat_q;
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    a_d      = req_a_i;
                    b_d      = req_sub_i ? ~req_b_i : req_b_i;
                    // A subtract is A + ~B + 1, so the +1 comes in as the first carry.
                    carry_d  = req_sub_i;
                    beat_d   = '0;
                    result_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                add_a_o   = a_q[off +: SLICE];
                add_b_o   = b_q[off +: SLICE];
                add_cin_o = carry_q;
                if (abort_i) begin
                    beat_d  = '0;
                    state_d = StIdle;
                end else begin
                    result_d[off +: SLICE] = add_sum_i;
                    carry_d = add_cout_i;
                    beat_d  = beat_q + BeatW'(1);
                    if (beat_q == LastBeat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            beat_q   <= beat_d;
        end
    end

    logic done;
    assign done         = (state_q == StDone);
    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = done;
    assign resp_sum_o   = done ? result_q : '0;
    assign resp_cout_o  = done & carry_q;
    // Same-sign operands (after the B inversion) that give a result of the other sign.
    assign resp_ovf_o   = done & (a_q[WIDTH-1] == b_q[WIDTH-1])
                               & (result_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;

    localparam int W = 64;
    localparam int S = 16;
    localparam int NB = W / S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_sub, abort;
    logic [W-1:0]  req_a, req_b;
    logic          resp_valid, resp_ready, resp_cout, resp_ovf;
    logic [W-1:0]  resp_sum;
    logic [S-1:0]  add_a, add_b, add_sum;
    logic          add_cin, add_cout;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared combinational CLA slice.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{S{1'b0}}, add_cin};

    wide_add_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_sub_i   (req_sub),
        .abort_i     (abort),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_sum_o  (resp_sum),
        .resp_cout_o (resp_cout),
        .resp_ovf_o  (resp_ovf),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_sum_i   (add_sum),
        .add_cout_i  (add_cout)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic; overflow from the exact signed result.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        logic [W:0]          u;
        logic signed [W+1:0] s;
        logic                cout;
        logic                ovf;
        if (sub) begin
            s    = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
            cout = (a >= b);
        end else begin
            s    = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
            u    = {1'b0, a} + {1'b0, b};
            cout = u[W];
        end
        ovf = (s[W] != s[W-1]);
        return {ovf, cout, s[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        wait_ready();
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        step();
        // Scramble request inputs; they must have no effect after accept.
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_sub   = 1'($urandom);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input int hold, input logic [W-1:0] e_sum,
                         input logic e_cout, input logic e_ovf);
        int lat;
        issue(a, b, sub);
        wait_resp(lat);
        check({tag, "_lat"}, lat, NB);
        // Stall the consumer; abort is also raised here and must be ignored in DONE.
        for (int i = 0; i < hold; i++) begin
            abort = 1'b1;
            step();
            check({tag, "_hold_valid"}, resp_valid, 1);
            check({tag, "_hold_sum"}, resp_sum, e_sum);
            check({tag, "_hold_rdy"}, req_ready, 0);
        end
        abort = 1'b0;
        check({tag, "_sum"}, resp_sum, e_sum);
        check({tag, "_cout"}, resp_cout, e_cout);
        check({tag, "_ovf"}, resp_ovf, e_ovf);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_idle_rdy"}, req_ready, 1);
        check({tag, "_idle_valid"}, resp_valid, 0);
    endtask

    task automatic do_abort(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input int k);
        issue(a, b, sub);
        repeat (k) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check({tag, "_rdy"}, req_ready, 1);
        check({tag, "_valid"}, resp_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W+1:0] r;
        logic [W-1:0] a, b;
        logic         sub;
        int           t[3];
        int           lat;

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
        abort = 1'b0; resp_ready = 1'b0;
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_cout", resp_cout, 0);
        check("rst_ovf", resp_ovf, 0);
        check("rst_slice", {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 64'd0, 1'b1, 1'b0);
        do_op("borrow", 64'd5, 64'd7, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        do_op("noborrow", 64'd7, 64'd5, 1'b1, 0, 64'd2, 1'b1, 1'b0);
        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        do_op("bp", 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 5,
              64'h1234_6789_BCDF_1233, 1'b0, 1'b0);

        // Back-to-back stream with the consumer always ready.
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            t[i] = cyc;
            issue(64'(i + 10), 64'd100, 1'b0);
            wait_resp(lat);
            check("stream_sum", resp_sum, 64'(i + 110));
            step();
        end
        resp_ready = 1'b0;
        check("stream_gap1", t[1] - t[0], NB + 2);
        check("stream_gap2", t[2] - t[1], NB + 2);

        // Abort while beat 2 is on the slice; then a clean operation.
        do_abort("abort", 64'hDEAD_BEEF_0000_0001, 64'h42, 1'b0, 2);
        repeat (NB + 1) begin
            step();
            check("abort_quiet", resp_valid, 0);
        end
        do_op("post_abort", 64'h1234, 64'h1, 1'b0, 0, 64'h1235, 1'b0, 1'b0);

        // Reset while a result is pending.
        issue(64'd3, 64'd4, 1'b0);
        wait_resp(lat);
        check("prerst_valid", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_valid", resp_valid, 0);
        check("rst_done_ready", req_ready, 1);
        check("rst_done_sum", resp_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10000; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sub = 1'($urandom);
            case ($urandom % 8)
                0: a = '1;
                1: b = 64'h8000_0000_0000_0000;
                2: b = a;
                default: ;
            endcase
            if ($urandom % 16 == 0) begin
                do_abort("rnd_abort", a, b, sub, int'($urandom % NB));
            end else begin
                r = ref_op(a, b, sub);
                do_op("rnd", a, b, sub, ($urandom % 4 == 0) ? int'($urandom % 3) : 0,
                      r[W-1:0], r[W], r[W+1]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
